uart_rx_frame: RTL and testbench

Asynchronous serial receiver that feeds the hex-display capture top. It oversamples the `RxD_i` line, recovers one character frame of 5–8 data bits with optional parity, and presents the byte with a one-cycle ready strobe and error flags. The port set matches the receiver slot in the display top, so this block drops in as that top's upstream stage.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_frame.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, oversample
// tick positions and the data-bit length base.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam int unsigned TICK_SAMPLE_A = 7;
    localparam int unsigned TICK_SAMPLE_B = 8;
    localparam int unsigned TICK_DECIDE   = 9;   // also the third sample
    localparam int unsigned TICK_END      = 15;
    localparam int unsigned BITLEN_BASE   = 5;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: divides the clock by DIV while running and emits
// a one-cycle tick at the end of each period. Clear restarts the period.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || !i_run || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_run && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: 5-8 data bits, optional parity, majority-vote
// bit decisions, one-cycle ready strobe with parity/framing error flags.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int OVS    = 16
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic       RxD_i,
    input  logic [1:0] Rx_BitLength_i,
    input  logic       Rx_ParityEN_i,
    input  logic       Rx_OddParity_i,
    input  logic       Rx_Enable_i,
    output logic [7:0] Rx_Data_o,
    output logic       RxD_Ready_o,
    output logic       RxD_ParityError_o,
    output logic       RxD_FramingError_o,
    output logic       Rx_operation_o,
    output logic       Rx_ShiftClock_o
);

    localparam int DIV_RAW = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = $clog2(OVS);

    rx_state_t     r_state, w_state_next;
    logic          r_rxd_s1, r_rxd_s2, r_rxd_prev;
    logic [TW-1:0] r_tick_idx;
    logic          r_samp_a, r_samp_b;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic [1:0]    r_len;
    logic          r_par_en, r_odd, r_par_acc, r_par_err;

    logic w_tick, w_run, w_start, w_decide, w_bit_end, w_bit, w_last_bit;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .i_clk   (m_clock),
        .i_rst_n (p_reset),
        .i_run   (w_run),
        .i_clear (w_start),
        .o_tick  (w_tick)
    );

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_s1   <= RxD_i;
            r_rxd_s2   <= r_rxd_s1;
            r_rxd_prev <= r_rxd_s2;
        end
    end

    assign w_start    = (r_state == ST_IDLE) && Rx_Enable_i && r_rxd_prev && !r_rxd_s2;
    assign w_bit_end  = w_tick && (r_tick_idx == TW'(TICK_END));
    assign w_bit      = majority3(r_samp_a, r_samp_b, r_rxd_s2);
    assign w_last_bit = (r_bit_cnt == (3'(BITLEN_BASE - 1) + {1'b0, r_len}));
    assign w_decide   = w_tick && (r_tick_idx == TW'(TICK_DECIDE)) &&
                        (r_state != ST_IDLE) && (r_state != ST_BREAK);

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!Rx_Enable_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_start) w_state_next = ST_START;
                ST_START: begin
                    if (w_decide && w_bit) w_state_next = ST_IDLE;
                    else if (w_bit_end)    w_state_next = ST_DATA;
                end
                ST_DATA:   if (w_bit_end && w_last_bit)
                               w_state_next = r_par_en ? ST_PARITY : ST_STOP;
                ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
                ST_STOP:   if (w_decide) w_state_next = w_bit ? ST_IDLE : ST_BREAK;
                ST_BREAK:  if (r_rxd_s2) w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_run           = (r_state != ST_IDLE);
        Rx_operation_o  = (r_state != ST_IDLE);
        Rx_ShiftClock_o = w_decide && Rx_Enable_i;
    end

    // Tick index restarts with every new frame so tick 0 aligns with the start edge.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_tick_idx <= '0;
        end else if ((r_state == ST_IDLE) || w_start) begin
            r_tick_idx <= '0;
        end else if (w_tick) begin
            r_tick_idx <= r_tick_idx + 1'b1;
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_samp_a           <= 1'b1;
            r_samp_b           <= 1'b1;
            r_shift            <= '0;
            r_bit_cnt          <= '0;
            r_len              <= '0;
            r_par_en           <= 1'b0;
            r_odd              <= 1'b0;
            r_par_acc          <= 1'b0;
            r_par_err          <= 1'b0;
            Rx_Data_o          <= '0;
            RxD_Ready_o        <= 1'b0;
            RxD_ParityError_o  <= 1'b0;
            RxD_FramingError_o <= 1'b0;
        end else begin
            RxD_Ready_o <= 1'b0;
            if (w_tick && (r_tick_idx == TW'(TICK_SAMPLE_A))) r_samp_a <= r_rxd_s2;
            if (w_tick && (r_tick_idx == TW'(TICK_SAMPLE_B))) r_samp_b <= r_rxd_s2;
            if (w_start) begin
                r_len     <= Rx_BitLength_i;
                r_par_en  <= Rx_ParityEN_i;
                r_odd     <= Rx_OddParity_i;
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_par_acc <= 1'b0;
                r_par_err <= 1'b0;
            end
            // An abort in the same cycle as a decision suppresses every update.
            if (Rx_Enable_i) begin
                if (w_decide) begin
                    case (r_state)
                        ST_DATA: begin
                            r_shift[r_bit_cnt] <= w_bit;
                            r_par_acc          <= r_par_acc ^ w_bit;
                        end
                        ST_PARITY: r_par_err <= r_par_acc ^ w_bit ^ r_odd;
                        ST_STOP: begin
                            Rx_Data_o          <= r_shift;
                            RxD_ParityError_o  <= r_par_en & r_par_err;
                            RxD_FramingError_o <= ~w_bit;
                            RxD_Ready_o        <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (w_bit_end && (r_state == ST_DATA) && !w_last_bit) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: drives serial frames and compares
// captured strobes against expectations derived from the frame contents.
module tb_uart_rx_frame;

    localparam int CLK_HZ = 6_400_000;
    localparam int BAUD   = 100_000;
    localparam int OVS    = 16;
    localparam int BITC   = CLK_HZ / BAUD;   // clock cycles per serial bit

    logic       m_clock;
    logic       p_reset;
    logic       RxD_i;
    logic [1:0] Rx_BitLength_i;
    logic       Rx_ParityEN_i;
    logic       Rx_OddParity_i;
    logic       Rx_Enable_i;
    logic [7:0] Rx_Data_o;
    logic       RxD_Ready_o;
    logic       RxD_ParityError_o;
    logic       RxD_FramingError_o;
    logic       Rx_operation_o;
    logic       Rx_ShiftClock_o;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } cap_t;

    cap_t       cap_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         shift_cnt = 0;
    int         dbl_cnt = 0;
    logic       ready_prev = 1'b0;
    logic [7:0] last_data = 8'h00;

    uart_rx_frame #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) dut (
        .m_clock            (m_clock),
        .p_reset            (p_reset),
        .RxD_i              (RxD_i),
        .Rx_BitLength_i     (Rx_BitLength_i),
        .Rx_ParityEN_i      (Rx_ParityEN_i),
        .Rx_OddParity_i     (Rx_OddParity_i),
        .Rx_Enable_i        (Rx_Enable_i),
        .Rx_Data_o          (Rx_Data_o),
        .RxD_Ready_o        (RxD_Ready_o),
        .RxD_ParityError_o  (RxD_ParityError_o),
        .RxD_FramingError_o (RxD_FramingError_o),
        .Rx_operation_o     (Rx_operation_o),
        .Rx_ShiftClock_o    (Rx_ShiftClock_o)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    // Output monitor, sampled on the inactive edge.
    always @(negedge m_clock) begin
        cap_t c;
        if (RxD_Ready_o) begin
            c.d  = Rx_Data_o;
            c.pe = RxD_ParityError_o;
            c.fe = RxD_FramingError_o;
            cap_q.push_back(c);
            if (ready_prev) dbl_cnt++;
        end
        ready_prev = RxD_Ready_o;
        if (Rx_ShiftClock_o) shift_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge m_clock);
    endtask

    task automatic drive_bit(input logic b);
        @(negedge m_clock);
        RxD_i = b;
        repeat (BITC - 1) @(negedge m_clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                              input logic pbit, input logic stopb);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stopb);
    endtask

    task automatic set_cfg(input int nbits, input logic pen, input logic odd);
        Rx_BitLength_i = 2'(nbits - 5);
        Rx_ParityEN_i  = pen;
        Rx_OddParity_i = odd;
    endtask

    function automatic cap_t pop_cap();
        cap_t c;
        c.d = 8'hxx; c.pe = 1'bx; c.fe = 1'bx;
        if (cap_q.size() > 0) c = cap_q.pop_front();
        return c;
    endfunction

    task automatic test_reset();
        p_reset = 1'b0;
        RxD_i = 1'b1;
        Rx_Enable_i = 1'b1;
        set_cfg(8, 1'b0, 1'b0);
        idle(3);
        n_vec++; if (Rx_Data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", Rx_Data_o); end
        n_vec++; if (RxD_Ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", RxD_Ready_o); end
        n_vec++; if (RxD_ParityError_o !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", RxD_ParityError_o); end
        n_vec++; if (RxD_FramingError_o !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", RxD_FramingError_o); end
        n_vec++; if (Rx_operation_o !== 1'b0) begin n_err++; $display("FAIL reset_op: got %b want 0", Rx_operation_o); end
        n_vec++; if (Rx_ShiftClock_o !== 1'b0) begin n_err++; $display("FAIL reset_shclk: got %b want 0", Rx_ShiftClock_o); end
        @(negedge m_clock);
        p_reset = 1'b1;
        idle(5);
        $display("reset checked");
    endtask

    task automatic test_8n1();
        cap_t c;
        int   s0;
        cap_q.delete();
        set_cfg(8, 1'b0, 1'b0);
        s0 = shift_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        idle(20);
        n_vec++; if (cap_q.size() != 1) begin n_err++; $display("FAIL 8n1_strobes: got %0d want 1", cap_q.size()); end
        c = pop_cap();
        n_vec++; if (c.d !== 8'hA5) begin n_err++; $display("FAIL 8n1_data: got %h want a5", c.d); end
        n_vec++; if (c.pe !== 1'b0 || c.fe !== 1'b0) begin n_err++; $display("FAIL 8n1_err: got pe=%b fe=%b want 0/0", c.pe, c.fe); end
        n_vec++; if (shift_cnt - s0 != 10) begin n_err++; $display("FAIL 8n1_shiftclk: got %0d want 10", shift_cnt - s0); end
        last_data = 8'hA5;
        $display("frame 8N1 a5 received %h", c.d);
    endtask

    task automatic test_parity();
        cap_t c;
        cap_q.delete();
        set_cfg(7, 1'b1, 1'b1);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        idle(10);
        c = pop_cap();
        n_vec++; if (c.d !== 8'h41) begin n_err++; $display("FAIL par_good_data: got %h want 41", c.d); end
        n_vec++; if (c.pe !== 1'b0) begin n_err++; $display("FAIL par_good_pe: got %b want 0", c.pe); end
        $display("frame 7O1 41 pbit=1 pe=%b", c.pe);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
        idle(10);
        c = pop_cap();
        n_vec++; if (c.d !== 8'h41) begin n_err++; $display("FAIL par_bad_data: got %h want 41", c.d); end
        n_vec++; if (c.pe !== 1'b1) begin n_err++; $display("FAIL par_bad_pe: got %b want 1", c.pe); end
        last_data = 8'h41;
        $display("frame 7O1 41 pbit=0 pe=%b", c.pe);
    endtask

    task automatic test_framing();
        cap_t c;
        cap_q.delete();
        set_cfg(8, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        idle(2 * BITC);
        n_vec++; if (Rx_operation_o !== 1'b1) begin n_err++; $display("FAIL brk_op_low: got %b want 1", Rx_operation_o); end
        RxD_i = 1'b1;
        idle(20);
        n_vec++; if (Rx_operation_o !== 1'b0) begin n_err++; $display("FAIL brk_op_high: got %b want 0", Rx_operation_o); end
        c = pop_cap();
        n_vec++; if (c.d !== 8'h3C || c.fe !== 1'b1 || c.pe !== 1'b0) begin
            n_err++; $display("FAIL frm_err: got d=%h fe=%b pe=%b want 3c/1/0", c.d, c.fe, c.pe); end
        idle(2 * BITC);
        n_vec++; if (cap_q.size() != 0) begin n_err++; $display("FAIL frm_extra_strobe: got %0d want 0", cap_q.size()); end
        last_data = 8'h3C;
        $display("frame 8N1 3c stop=0 fe=%b", c.fe);
    endtask

    task automatic test_glitch();
        cap_q.delete();
        @(negedge m_clock);
        RxD_i = 1'b0;
        idle(4 * BITC / OVS);
        RxD_i = 1'b1;
        n_vec++; if (Rx_operation_o !== 1'b1) begin n_err++; $display("FAIL glitch_op_start: got %b want 1", Rx_operation_o); end
        idle(40);
        n_vec++; if (Rx_operation_o !== 1'b0) begin n_err++; $display("FAIL glitch_op_end: got %b want 0", Rx_operation_o); end
        n_vec++; if (cap_q.size() != 0) begin n_err++; $display("FAIL glitch_strobe: got %0d want 0", cap_q.size()); end
        $display("glitch of 4 ticks rejected");
    endtask

    task automatic test_random();
        cap_t       c;
        logic [7:0] d;
        int         nb, s0, exp_shift;
        logic       pen, odd, pbit, exp_pe;
        for (int k = 0; k < 12; k++) begin
            cap_q.delete();
            nb   = 5 + int'($urandom_range(0, 3));
            pen  = 1'($urandom);
            odd  = 1'($urandom);
            pbit = 1'($urandom);
            d    = 8'($urandom) & 8'((1 << nb) - 1);
            exp_pe    = pen && ((($countones(d) + int'(pbit) + int'(odd)) % 2) != 0);
            exp_shift = 2 + nb + int'(pen);
            set_cfg(nb, pen, odd);
            s0 = shift_cnt;
            send_frame(d, nb, pen, pbit, 1'b1);
            idle(5);
            c = pop_cap();
            n_vec++; if (c.d !== d || c.pe !== exp_pe || c.fe !== 1'b0) begin
                n_err++; $display("FAIL rand%0d: got d=%h pe=%b fe=%b want %h/%b/0", k, c.d, c.pe, c.fe, d, exp_pe); end
            n_vec++; if (shift_cnt - s0 != exp_shift) begin
                n_err++; $display("FAIL rand%0d_shiftclk: got %0d want %0d", k, shift_cnt - s0, exp_shift); end
            last_data = d;
            $display("frame rand%0d bits=%0d pen=%b odd=%b d=%h pe=%b", k, nb, pen, odd, c.d, c.pe);
            idle(int'($urandom_range(0, 30)));
        end
    endtask

    task automatic test_abort();
        cap_t c;
        cap_q.delete();
        set_cfg(8, 1'b0, 1'b0);
        fork
            send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1);
            begin
                idle(3 * BITC + 30);
                Rx_Enable_i = 1'b0;
                idle(2);
                n_vec++; if (Rx_operation_o !== 1'b0) begin n_err++; $display("FAIL abort_op: got %b want 0", Rx_operation_o); end
                idle(5);
                Rx_Enable_i = 1'b1;
            end
        join
        idle(20);
        n_vec++; if (cap_q.size() != 0) begin n_err++; $display("FAIL abort_strobe: got %0d want 0", cap_q.size()); end
        n_vec++; if (Rx_Data_o !== last_data) begin n_err++; $display("FAIL abort_hold: got %h want %h", Rx_Data_o, last_data); end
        $display("frame ff aborted, data held %h", Rx_Data_o);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1);
        idle(10);
        c = pop_cap();
        n_vec++; if (c.d !== 8'h12 || c.fe !== 1'b0) begin n_err++; $display("FAIL after_abort: got d=%h fe=%b want 12/0", c.d, c.fe); end
        last_data = 8'h12;
        $display("frame 12 after abort received %h", c.d);
    endtask

    task automatic test_reset_mid();
        cap_q.delete();
        fork
            send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
            begin
                idle(300);
                p_reset = 1'b0;
                idle(2);
                n_vec++; if (Rx_Data_o !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", Rx_Data_o); end
                n_vec++; if (Rx_operation_o !== 1'b0 || RxD_Ready_o !== 1'b0 ||
                             RxD_ParityError_o !== 1'b0 || RxD_FramingError_o !== 1'b0) begin
                    n_err++; $display("FAIL rstmid_flags: got op=%b rdy=%b pe=%b fe=%b want 0/0/0/0",
                                      Rx_operation_o, RxD_Ready_o, RxD_ParityError_o, RxD_FramingError_o); end
            end
        join
        @(negedge m_clock);
        p_reset = 1'b1;
        idle(20);
        n_vec++; if (cap_q.size() != 0) begin n_err++; $display("FAIL rstmid_strobe: got %0d want 0", cap_q.size()); end
        last_data = 8'h00;
        $display("reset mid-frame cleared outputs");
    endtask

    task automatic test_back_to_back();
        cap_t c0, c1;
        cap_q.delete();
        dbl_cnt = 0;
        set_cfg(8, 1'b0, 1'b0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1);
        idle(20);
        n_vec++; if (cap_q.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", cap_q.size()); end
        c0 = pop_cap();
        c1 = pop_cap();
        n_vec++; if (c0.d !== 8'h55 || c0.fe !== 1'b0) begin n_err++; $display("FAIL b2b_first: got %h fe=%b want 55/0", c0.d, c0.fe); end
        n_vec++; if (c1.d !== 8'hAA || c1.fe !== 1'b0) begin n_err++; $display("FAIL b2b_second: got %h fe=%b want aa/0", c1.d, c1.fe); end
        n_vec++; if (dbl_cnt != 0) begin n_err++; $display("FAIL strobe_width: got %0d wide strobes want 0", dbl_cnt); end
        $display("frames b2b received %h %h", c0.d, c1.d);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_glitch();
        test_random();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
